mem_port_arbiter: RTL and testbench

- Sequences a single shared memory bus between the instruction-fetch (IF) port and the data-memory (MEM) port of the 5-stage RISC-V pipeline.
- Owns a small request/response state machine and per-requester acknowledgement.
- Generates the stall signals that feed the pipeline's pc_en / if_id_en hazard logic.
- Sits between the data path's memory interfaces and the external memory bus.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter_arb_prio.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/MEM memory-port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam logic [3:0]  BE_FULL   = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, bus and status bundle of the memory-port arbiter.
// Suffixes are from the arbiter's point of view: slave = arbiter, master = environment.
interface mem_port_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;

    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [3:0]  dm_be_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;

    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    logic        stall_if_o;
    logic        stall_mem_o;
    logic        err_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_rdata_o, if_ack_o,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_be_i,
        output dm_rdata_o, dm_ack_o,
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i,
        output stall_if_o, stall_mem_o, err_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_rdata_o, if_ack_o,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_be_i,
        input  dm_rdata_o, dm_ack_o,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i,
        input  stall_if_o, stall_mem_o, err_o
    );
endinterface

// File: rtl/mem_port_arbiter_arb_prio.sv
// Owner pick for the shared bus: MEM first, IF forced after STARVE_LIMIT
// consecutive data grants taken while a fetch was waiting.
module arb_prio
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   if_req_i,
    input  logic   dm_req_i,
    input  logic   grant_en_i,
    output logic   pick_valid_o,
    output owner_e pick_owner_o
);
    localparam int CW = $clog2(STARVE_LIMIT + 2);

    logic [CW-1:0] starve_cnt_q;
    logic [CW-1:0] starve_cnt_d;
    logic          if_forced;

    always_comb begin
        if_forced    = if_req_i && (starve_cnt_q == CW'(STARVE_LIMIT));
        pick_valid_o = if_req_i || dm_req_i;
        pick_owner_o = (dm_req_i && !if_forced) ? OWN_MEM : OWN_IF;

        starve_cnt_d = starve_cnt_q;
        if (!if_req_i) begin
            starve_cnt_d = '0;
        end else if (grant_en_i && pick_valid_o) begin
            // A MEM grant here always has if_forced low, so the count stays <= limit
            if (pick_owner_o == OWN_IF) starve_cnt_d = '0;
            else                        starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) starve_cnt_q <= '0;
        else      starve_cnt_q <= starve_cnt_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory bus between the IF and MEM pipeline ports,
// with per-port ack/rdata, pipeline stall outputs and a sticky timeout flag.
//
//   state | meaning
//   IDLE  | no transaction; pick an owner and latch its request fields
//   REQ   | bus_req_o high, waiting for bus_gnt_i
//   WAIT  | address accepted, waiting for bus_rvalid_i
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave port
);
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    arb_state_e    state_q;
    owner_e        owner_q;
    logic [TW-1:0] tmo_cnt_q;
    logic          bus_req_q;
    logic          bus_we_q;
    logic [31:0]   bus_addr_q;
    logic [31:0]   bus_wdata_q;
    logic [3:0]    bus_be_q;
    logic          if_ack_q;
    logic          dm_ack_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   dm_rdata_q;
    logic          err_q;

    logic          pick_valid;
    owner_e        pick_owner;
    logic          done;
    logic          abort;
    logic [31:0]   if_resp;
    logic [31:0]   dm_resp;

    arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (port.if_req_i),
        .dm_req_i     (port.dm_req_i),
        .grant_en_i   (state_q == IDLE),
        .pick_valid_o (pick_valid),
        .pick_owner_o (pick_owner)
    );

    // A response on the last allowed cycle counts as a completion, not a timeout
    always_comb begin
        done    = (state_q == WAIT) && port.bus_rvalid_i;
        abort   = (state_q != IDLE) && !done && (tmo_cnt_q == TMO_LAST);
        if_resp = done ? port.bus_rdata_i : NOP_INSTR;
        dm_resp = (done && !bus_we_q) ? port.bus_rdata_i : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            tmo_cnt_q   <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        owner_q   <= pick_owner;
                        tmo_cnt_q <= '0;
                        bus_req_q <= 1'b1;
                        state_q   <= REQ;
                        if (pick_owner == OWN_MEM) begin
                            bus_we_q    <= port.dm_we_i;
                            bus_addr_q  <= port.dm_addr_i;
                            bus_wdata_q <= port.dm_wdata_i;
                            bus_be_q    <= port.dm_be_i;
                        end else begin
                            bus_we_q    <= 1'b0;
                            bus_addr_q  <= port.if_addr_i;
                            bus_wdata_q <= '0;
                            bus_be_q    <= BE_FULL;
                        end
                    end
                end
                REQ, WAIT: begin
                    if (done || abort) begin
                        bus_req_q <= 1'b0;
                        state_q   <= IDLE;
                        if (abort) err_q <= 1'b1;
                        if (owner_q == OWN_MEM) begin
                            dm_ack_q   <= 1'b1;
                            dm_rdata_q <= dm_resp;
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= if_resp;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        if (state_q == REQ && port.bus_gnt_i) begin
                            bus_req_q <= 1'b0;
                            state_q   <= WAIT;
                        end
                    end
                end
                default: begin
                    bus_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign port.bus_req_o   = bus_req_q;
    assign port.bus_we_o    = bus_we_q;
    assign port.bus_addr_o  = bus_addr_q;
    assign port.bus_wdata_o = bus_wdata_q;
    assign port.bus_be_o    = bus_be_q;
    assign port.if_ack_o    = if_ack_q;
    assign port.dm_ack_o    = dm_ack_q;
    assign port.if_rdata_o  = if_rdata_q;
    assign port.dm_rdata_o  = dm_rdata_q;
    assign port.err_o       = err_q;
    assign port.stall_if_o  = port.if_req_i && !if_ack_q;
    assign port.stall_mem_o = port.dm_req_i && !dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic, checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int          TMO  = 8;
    localparam int          SLIM = 4;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if arb_if ();

    mem_port_arbiter #(
        .TIMEOUT_CYCLES (TMO),
        .STARVE_LIMIT   (SLIM)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .port (arb_if)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one outstanding transaction, its age, and the expected outputs
    bit          m_busy, m_addr_phase, m_own_mem;
    bit          m_hang, m_fixed, m_garbage, m_force;
    int          m_age, m_starve, gnt_wait, rv_wait, fix_gnt, fix_rv;
    logic [31:0] force_data;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic        exp_bus_req, exp_if_ack, exp_dm_ack, exp_err;
    logic [31:0] exp_if_rdata, exp_dm_rdata;
    bit          auto_if, auto_dm, dm_hold;
    logic        prev_bus_req;
    logic [31:0] obs_addr [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_addr_phase = 0; m_own_mem = 0; m_age = 0; m_starve = 0;
        exp_bus_req = 0; exp_if_ack = 0; exp_dm_ack = 0; exp_err = 0;
        exp_if_rdata = '0; exp_dm_rdata = '0;
        prev_bus_req = 0;
    endtask

    task automatic finish_txn(input bit ok, input logic [31:0] data);
        m_busy = 0;
        exp_bus_req = 0;
        if (m_own_mem) begin
            exp_dm_ack   = 1;
            exp_dm_rdata = (ok && !e_we) ? data : 32'h0;
        end else begin
            exp_if_ack   = 1;
            exp_if_rdata = ok ? data : NOP;
        end
        if (!ok) exp_err = 1;
    endtask

    // Decide bus responses for the coming edge and what the outputs must be after it
    task automatic plan_edge();
        logic [31:0] rd;
        logic        g, v;
        bit          done;
        exp_if_ack = 0;
        exp_dm_ack = 0;
        rd = m_force ? force_data : $urandom;
        g = 0;
        v = 0;
        if (!arb_if.if_req_i) m_starve = 0;
        if (!m_busy) begin
            if (m_garbage) begin
                g = ($urandom_range(0, 3) == 0);
                v = ($urandom_range(0, 3) == 0);
            end
            if (arb_if.if_req_i || arb_if.dm_req_i) begin
                m_own_mem = arb_if.dm_req_i && !(arb_if.if_req_i && m_starve == SLIM);
                if (m_own_mem) begin
                    e_we = arb_if.dm_we_i; e_addr = arb_if.dm_addr_i;
                    e_wdata = arb_if.dm_wdata_i; e_be = arb_if.dm_be_i;
                    if (arb_if.if_req_i) m_starve++;
                end else begin
                    e_we = 0; e_addr = arb_if.if_addr_i; e_wdata = '0; e_be = 4'hF;
                    m_starve = 0;
                end
                m_busy = 1; m_addr_phase = 1; m_age = 0; exp_bus_req = 1;
                gnt_wait = m_fixed ? fix_gnt : $urandom_range(0, 2);
                rv_wait  = m_fixed ? fix_rv  : $urandom_range(0, 2);
            end
        end else begin
            done = 0;
            if (m_addr_phase) begin
                if (m_garbage) v = ($urandom_range(0, 3) == 0);
                if (!m_hang) begin
                    if (gnt_wait == 0) g = 1;
                    else gnt_wait--;
                end
            end else begin
                if (m_garbage) g = ($urandom_range(0, 3) == 0);
                if (rv_wait == 0) begin
                    v = 1;
                    done = 1;
                end else rv_wait--;
            end
            if (done) finish_txn(1, rd);
            else if (m_age == TMO - 1) finish_txn(0, 32'h0);
            else begin
                m_age++;
                if (m_addr_phase && g) begin
                    m_addr_phase = 0;
                    exp_bus_req  = 0;
                end
            end
        end
        arb_if.bus_gnt_i    = g;
        arb_if.bus_rvalid_i = v;
        arb_if.bus_rdata_i  = rd;
    endtask

    task automatic cycle();
        plan_edge();
        @(posedge clk);
        #1;
        chk("bus_req", arb_if.bus_req_o, exp_bus_req);
        if (exp_bus_req) begin
            chk("bus_addr", arb_if.bus_addr_o, e_addr);
            chk("bus_we", arb_if.bus_we_o, e_we);
            chk("bus_be", arb_if.bus_be_o, e_be);
            if (e_we) chk("bus_wdata", arb_if.bus_wdata_o, e_wdata);
        end
        chk("if_ack", arb_if.if_ack_o, exp_if_ack);
        chk("dm_ack", arb_if.dm_ack_o, exp_dm_ack);
        chk("if_rdata", arb_if.if_rdata_o, exp_if_rdata);
        chk("dm_rdata", arb_if.dm_rdata_o, exp_dm_rdata);
        chk("err", arb_if.err_o, exp_err);
        chk("stall_if", arb_if.stall_if_o, arb_if.if_req_i && !exp_if_ack);
        chk("stall_mem", arb_if.stall_mem_o, arb_if.dm_req_i && !exp_dm_ack);
        if (arb_if.bus_req_o && !prev_bus_req) obs_addr.push_back(arb_if.bus_addr_o);
        prev_bus_req = arb_if.bus_req_o;
        // requesters drop (or replace) their request on ack
        if (exp_if_ack) arb_if.if_req_i = 0;
        if (!arb_if.if_req_i && auto_if && $urandom_range(0, 3) == 0) begin
            arb_if.if_req_i  = 1;
            arb_if.if_addr_i = $urandom & 32'hFFFF_FFFC;
        end
        if (exp_dm_ack) begin
            if (dm_hold) arb_if.dm_addr_i = arb_if.dm_addr_i + 32'd4;
            else         arb_if.dm_req_i  = 0;
        end
        if (!arb_if.dm_req_i && auto_dm && $urandom_range(0, 2) == 0) begin
            arb_if.dm_req_i   = 1;
            arb_if.dm_we_i    = $urandom_range(0, 1);
            arb_if.dm_addr_i  = $urandom & 32'hFFFF_FFFC;
            arb_if.dm_wdata_i = $urandom;
            arb_if.dm_be_i    = 4'($urandom_range(1, 15));
        end
    endtask

    task automatic run_until_idle(input string tag, input int max);
        int n = 0;
        while ((m_busy || arb_if.if_req_i || arb_if.dm_req_i) && n < max) begin
            cycle();
            n++;
        end
        chk({tag, "_bound"}, (n < max), 1);
    endtask

    task automatic fetch(input logic [31:0] addr);
        arb_if.if_req_i  = 1;
        arb_if.if_addr_i = addr;
    endtask

    task automatic data_req(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        arb_if.dm_req_i   = 1;
        arb_if.dm_we_i    = we;
        arb_if.dm_addr_i  = addr;
        arb_if.dm_wdata_i = wdata;
        arb_if.dm_be_i    = be;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        arb_if.if_req_i = 0; arb_if.if_addr_i = '0;
        arb_if.dm_req_i = 0; arb_if.dm_we_i = 0; arb_if.dm_addr_i = '0;
        arb_if.dm_wdata_i = '0; arb_if.dm_be_i = '0;
        arb_if.bus_gnt_i = 0; arb_if.bus_rvalid_i = 0; arb_if.bus_rdata_i = '0;
        m_hang = 0; m_fixed = 0; m_garbage = 0; m_force = 0; force_data = '0;
        fix_gnt = 0; fix_rv = 0; auto_if = 0; auto_dm = 0; dm_hold = 0;
        model_reset();

        // reset state
        #1;
        chk("rst_bus_req", arb_if.bus_req_o, 0);
        chk("rst_bus_addr", arb_if.bus_addr_o, 0);
        chk("rst_bus_be", arb_if.bus_be_o, 0);
        chk("rst_acks", {arb_if.if_ack_o, arb_if.dm_ack_o}, 0);
        chk("rst_rdata", arb_if.if_rdata_o | arb_if.dm_rdata_o, 0);
        chk("rst_err", arb_if.err_o, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;

        // single fetch at minimum latency
        m_fixed = 1; fix_gnt = 0; fix_rv = 0; m_force = 1; force_data = 32'h00500093;
        fetch(32'h10);
        #1;
        chk("t1_stall_c0", arb_if.stall_if_o, 1);
        cycle();
        chk("t1_bus_req_c1", arb_if.bus_req_o, 1);
        chk("t1_addr", arb_if.bus_addr_o, 32'h10);
        chk("t1_be", arb_if.bus_be_o, 4'hF);
        chk("t1_stall_c1", arb_if.stall_if_o, 1);
        cycle();
        chk("t1_stall_c2", arb_if.stall_if_o, 1);
        chk("t1_no_ack_c2", arb_if.if_ack_o, 0);
        cycle();
        chk("t1_ack_c3", arb_if.if_ack_o, 1);
        chk("t1_rdata", arb_if.if_rdata_o, 32'h00500093);
        cycle();
        chk("t1_ack_pulse", arb_if.if_ack_o, 0);
        chk("t1_rdata_hold", arb_if.if_rdata_o, 32'h00500093);

        // simultaneous IF and MEM: MEM first
        m_fixed = 0; m_force = 0;
        base = obs_addr.size();
        fetch(32'h14);
        data_req(0, 32'h200, 32'h0, 4'hF);
        run_until_idle("t2", 40);
        chk("t2_first", obs_addr[base], 32'h200);
        chk("t2_second", obs_addr[base+1], 32'h14);

        // store
        m_fixed = 1; m_force = 1; force_data = 32'h12345678;
        data_req(1, 32'h40, 32'hDEADBEEF, 4'b0011);
        cycle();
        chk("t3_we", arb_if.bus_we_o, 1);
        chk("t3_addr", arb_if.bus_addr_o, 32'h40);
        chk("t3_wdata", arb_if.bus_wdata_o, 32'hDEADBEEF);
        chk("t3_be", arb_if.bus_be_o, 4'b0011);
        run_until_idle("t3", 20);
        chk("t3_rdata", arb_if.dm_rdata_o, 32'h0);
        arb_if.dm_we_i = 0;

        // starvation: 4 MEM grants, then IF, then MEM again
        m_fixed = 0; m_force = 0;
        base = obs_addr.size();
        dm_hold = 1;
        fetch(32'h1000);
        data_req(0, 32'h300, 32'h0, 4'hF);
        n = 0;
        while (arb_if.if_req_i && n < 60) begin
            cycle();
            n++;
        end
        chk("t4_if_bound", (n < 60), 1);
        dm_hold = 0;
        run_until_idle("t4", 40);
        for (int k = 0; k < 4; k++) chk("t4_mem_grant", obs_addr[base+k], 32'h300 + 32'(4 * k));
        chk("t4_if_grant", obs_addr[base+4], 32'h1000);
        chk("t4_mem_after", obs_addr[base+5], 32'h310);

        // random traffic with stray gnt/rvalid
        auto_if = 1; auto_dm = 1; m_garbage = 1;
        repeat (400) cycle();
        auto_if = 0; auto_dm = 0; m_garbage = 0;
        run_until_idle("t5", 60);

        // rvalid on the timeout-limit cycle completes normally
        m_fixed = 1; fix_gnt = 3; fix_rv = 3; m_force = 1; force_data = 32'hCAFE0013;
        fetch(32'h80);
        run_until_idle("t6", 30);
        chk("t6_rdata", arb_if.if_rdata_o, 32'hCAFE0013);
        chk("t6_err", arb_if.err_o, 0);

        // fetch timeout: no grant ever
        fix_gnt = 0; fix_rv = 0; m_hang = 1;
        fetch(32'h84);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!arb_if.if_ack_o && n < 20);
        chk("t7_abort_cycle", n, 9);
        chk("t7_nop", arb_if.if_rdata_o, 32'h00000013);
        chk("t7_err", arb_if.err_o, 1);
        run_until_idle("t7", 10);

        // MEM load then MEM timeout returns zero
        m_hang = 0; force_data = 32'h55AA55AA;
        data_req(0, 32'h88, 32'h0, 4'hF);
        run_until_idle("t7b", 20);
        chk("t7_load", arb_if.dm_rdata_o, 32'h55AA55AA);
        m_hang = 1;
        data_req(0, 32'h8C, 32'h0, 4'hF);
        run_until_idle("t7c", 20);
        chk("t7_dm_abort", arb_if.dm_rdata_o, 32'h0);
        m_hang = 0;
        fetch(32'h90);
        run_until_idle("t7d", 20);
        chk("t7_err_sticky", arb_if.err_o, 1);

        // async reset while in WAIT, then a clean fetch
        fix_gnt = 0; fix_rv = 5;
        fetch(32'h94);
        cycle();
        cycle();
        chk("t8_in_wait", arb_if.bus_req_o, 0);
        #3 rst = 0;
        #1;
        chk("t8_bus_req", arb_if.bus_req_o, 0);
        chk("t8_bus_addr", arb_if.bus_addr_o, 0);
        chk("t8_acks", {arb_if.if_ack_o, arb_if.dm_ack_o}, 0);
        chk("t8_err", arb_if.err_o, 0);
        chk("t8_rdata", arb_if.if_rdata_o, 0);
        arb_if.if_req_i = 0; arb_if.dm_req_i = 0;
        arb_if.bus_gnt_i = 0; arb_if.bus_rvalid_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("t8_no_ack_in_rst", arb_if.if_ack_o, 0);
        rst = 1;
        fix_gnt = 0; fix_rv = 0; force_data = 32'h00100073;
        fetch(32'hA0);
        run_until_idle("t8", 20);
        chk("t8_fetch", arb_if.if_rdata_o, 32'h00100073);
        chk("t8_err_clear", arb_if.err_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
